core_pipe_exec_div_seq: RTL and testbench
=========================================

Name: core_pipe_exec_div_seq

Overview:
- Multi-cycle sequencer for RV64M DIV/DIVU/REM/REMU and their W forms.
- Runs a restoring division by borrowing the execute-stage integer ALU for one subtract/compare per iteration.
- Sits beside the ALU in the execute stage and asserts a claim so the ALU operand mux selects its operands while busy.
- The execute stage stalls on req_valid && !rsp_valid.

Parameters:
- XLEN, 64, datapath width. XL = XLEN-1.

Ports:
- g_clk  input  1  core clock
- g_reset  input  1  synchronous active-high reset
- flush  input  1  abandon any in-flight operation
- req_valid  input  1  operation request
- req_ready  output  1  sequencer idle, can accept
- req_op  input  2  0=DIV 1=DIVU 2=REM 3=REMU
- req_word  input  1  32-bit (W) variant
- req_rs1  input  XLEN  dividend
- req_rs2  input  XLEN  divisor
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_result  output  XLEN  quotient or remainder
- alu_claim  output  1  sequencer owns the ALU this cycle
- alu_opr_a  output  XLEN  ALU operand A
- alu_opr_b  output  XLEN  ALU operand B
- alu_op_sub  output  1  ALU subtract select
- alu_word  output  1  ALU word select, always 0
- alu_add_out  input  XLEN  ALU adder result
- alu_cmp_ltu  input  1  ALU unsigned less-than

Behaviour:
- States: IDLE, ITER, FIX, DONE.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, alu_claim=0, all alu_* outputs 0, counters 0.
- req_ready=1 only in IDLE. A request is accepted on req_valid && req_ready && !flush.

Accept (IDLE):
- Signed op (DIV/REM): latch magnitudes of the operands, plus quotient sign (sa^sb) and remainder sign (sa).
- Word: operands are the low 32 bits, sign- or zero-extended per op. The dividend magnitude is preloaded into q[63:32], N=32.
- Otherwise q=|a|, N=64. rem=0, cnt=0, divisor d=|b|.
- Special cases go straight to DONE, result valid next cycle:
  - Divide by zero: quotient = all ones; remainder = dividend (word: sign-extended low 32).
  - Signed overflow (most-negative / -1, per width): quotient = dividend, remainder = 0.
- Normal case goes to ITER.

ITER, one iteration per cycle, alu_claim=1:
- shifted = {rem, q[63]} (65 bits).
- Drive alu_opr_a = shifted[63:0], alu_opr_b = d, alu_op_sub = 1.
- take = shifted[64] | !alu_cmp_ltu.
- rem <= take ? alu_add_out : shifted[63:0].
- q <= {q[62:0], take}. cnt++.
- After N iterations go to FIX.

FIX (1 cycle, no claim):
- Negate the quotient if its sign is set and the op is DIV.
- Negate the remainder if its sign is set and the op is REM.
- Select the output by op. Word results are sign-extended from bit 31.
- Register into rsp_result, then go to DONE.

DONE:
- rsp_valid=1 and rsp_result held stable until rsp_ready.
- On the handshake go to IDLE. req_ready rises in the following cycle; no back-to-back accept in the same cycle.

Latency, request accepted at cycle T:
- Normal 64-bit: rsp_valid from T+66.
- Normal word: rsp_valid from T+34.
- Special cases: rsp_valid from T+1.

Flush:
- Any state goes to IDLE next cycle. rsp_valid and alu_claim drop next cycle; no response is produced.
- Flush in the accept cycle discards the request.
- Flush has priority over rsp_ready and req_valid.

Other rules:
- When not in ITER: alu_claim=0 and alu_opr_a/alu_opr_b/alu_op_sub are driven 0.
- Reset mid-operation returns to the reset values next cycle.

Test Plan:
- DIVU 100/7 (64-bit) -> alu_claim high exactly 64 cycles; rsp_result=14 at T+66. Repeat with REMU -> 2.
- DIV -7/2 -> quotient 0xFFFF_FFFF_FFFF_FFFD (-3). REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF (-1); remainder sign follows the dividend.
- DIVUW rs1=0xFFFF_FFFF_8000_0000, rs2=2 -> 0x0000_0000_4000_0000 at T+34. DIVW same operands -> 0xFFFF_FFFF_C000_0000.
- Special cases, each valid at T+1 with no alu_claim:
  - DIV by zero -> all ones.
  - REM x/0 with x=0x1234 -> 0x1234.
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 (REM -> 0).
  - DIVW 0x8000_0000 / -1 -> 0xFFFF_FFFF_8000_0000.
- Handshake: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid and rsp_result stable, req_ready=0 throughout. Then rsp_ready=1 -> IDLE next cycle.
- Flush at ITER cycle 10 -> IDLE next cycle, alu_claim=0, no rsp_valid. A new DIVU 9/3 accepted afterwards returns 3.

Source files
------------

// File: rtl/core_pipe_exec_div_seq.sv
// Sequential RV64M divider (DIV/DIVU/REM/REMU and W forms). It performs a restoring division
// and borrows the execute-stage ALU for one subtract/compare per iteration.
module core_pipe_exec_div_seq #(
   parameter int XLEN = 64
) (
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  logic            req_word,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_result,
   output logic            alu_claim,
   output logic [XLEN-1:0] alu_opr_a,
   output logic [XLEN-1:0] alu_opr_b,
   output logic            alu_op_sub,
   output logic            alu_word,
   input  logic [XLEN-1:0] alu_add_out,
   input  logic            alu_cmp_ltu
);

   localparam int XL = XLEN - 1;
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] CNT_LAST_D = CW'(XLEN - 1);
   localparam logic [CW-1:0] CNT_LAST_W = CW'(31);
   localparam logic [1:0] OP_DIV = 2'd0;
   localparam logic [1:0] OP_REM = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

   function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
      return {{(XLEN-32){v[31]}}, v[31:0]};
   endfunction

   state_t            r_state;
   state_t            w_next;
   logic [XLEN-1:0]   r_q;
   logic [XLEN-1:0]   r_rem;
   logic [XLEN-1:0]   r_d;
   logic [CW-1:0]     r_cnt;
   logic [1:0]        r_op;
   logic              r_word;
   logic              r_neg_q;
   logic              r_neg_r;
   logic [XLEN-1:0]   r_rsp_result;

   // Operand decode for the request being offered
   logic              w_signed;
   logic [XLEN-1:0]   w_a_ext;
   logic [XLEN-1:0]   w_b_ext;
   logic              w_sa;
   logic              w_sb;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic [XLEN-1:0]   w_min;
   logic              w_div_zero;
   logic              w_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_spec_sel;
   logic [XLEN-1:0]   w_special_result;
   logic              w_accept;

   assign w_signed   = ~req_op[0];
   assign w_a_ext    = req_word ? (w_signed ? sext_w(req_rs1) : {{(XLEN-32){1'b0}}, req_rs1[31:0]}) : req_rs1;
   assign w_b_ext    = req_word ? (w_signed ? sext_w(req_rs2) : {{(XLEN-32){1'b0}}, req_rs2[31:0]}) : req_rs2;
   assign w_sa       = w_signed & w_a_ext[XL];
   assign w_sb       = w_signed & w_b_ext[XL];
   assign w_mag_a    = w_sa ? -w_a_ext : w_a_ext;
   assign w_mag_b    = w_sb ? -w_b_ext : w_b_ext;
   assign w_min      = req_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {XL{1'b0}}};
   assign w_div_zero = (w_b_ext == '0);
   assign w_ovf      = w_signed && (w_a_ext == w_min) && (&w_b_ext);
   assign w_special  = w_div_zero | w_ovf;
   // Div-by-zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
   assign w_spec_sel = req_op[1] ? (w_div_zero ? w_a_ext : '0) : (w_div_zero ? '1 : w_a_ext);
   assign w_special_result = req_word ? sext_w(w_spec_sel) : w_spec_sel;
   assign w_accept   = req_valid & (r_state == S_IDLE) & ~flush;

   // One restoring step: shift in the next dividend bit and subtract when it fits
   logic [XLEN:0]     w_shifted;
   logic              w_take;
   logic              w_last;

   assign w_shifted = {r_rem, r_q[XL]};
   assign w_take    = w_shifted[XLEN] | ~alu_cmp_ltu;
   assign w_last    = (r_cnt == (r_word ? CNT_LAST_W : CNT_LAST_D));

   logic [XLEN-1:0]   w_q_fix;
   logic [XLEN-1:0]   w_r_fix;
   logic [XLEN-1:0]   w_fix_sel;
   logic [XLEN-1:0]   w_fix_result;

   assign w_q_fix      = (r_neg_q && r_op == OP_DIV) ? -r_q : r_q;
   assign w_r_fix      = (r_neg_r && r_op == OP_REM) ? -r_rem : r_rem;
   assign w_fix_sel    = r_op[1] ? w_r_fix : w_q_fix;
   assign w_fix_result = r_word ? sext_w(w_fix_sel) : w_fix_sel;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge g_clk) begin
      if (g_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (req_valid) w_next = w_special ? S_DONE : S_ITER;
            S_ITER: if (w_last)    w_next = S_FIX;
            S_FIX:                 w_next = S_DONE;
            S_DONE: if (rsp_ready) w_next = S_IDLE;
            default:               w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready  = (r_state == S_IDLE);
      rsp_valid  = (r_state == S_DONE);
      rsp_result = r_rsp_result;
      alu_claim  = 1'b0;
      alu_opr_a  = '0;
      alu_opr_b  = '0;
      alu_op_sub = 1'b0;
      alu_word   = 1'b0;
      if (r_state == S_ITER) begin
         alu_claim  = 1'b1;
         alu_opr_a  = w_shifted[XL:0];
         alu_opr_b  = r_d;
         alu_op_sub = 1'b1;
      end
   end

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         r_q          <= '0;
         r_rem        <= '0;
         r_d          <= '0;
         r_cnt        <= '0;
         r_op         <= '0;
         r_word       <= 1'b0;
         r_neg_q      <= 1'b0;
         r_neg_r      <= 1'b0;
         r_rsp_result <= '0;
      end else if (w_accept) begin
         r_q     <= req_word ? {w_mag_a[31:0], {(XLEN-32){1'b0}}} : w_mag_a;
         r_rem   <= '0;
         r_d     <= w_mag_b;
         r_cnt   <= '0;
         r_op    <= req_op;
         r_word  <= req_word;
         r_neg_q <= w_sa ^ w_sb;
         r_neg_r <= w_sa;
         if (w_special) r_rsp_result <= w_special_result;
      end else if (r_state == S_ITER) begin
         r_rem <= w_take ? alu_add_out : w_shifted[XL:0];
         r_q   <= {r_q[XL-1:0], w_take};
         r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_FIX) begin
         r_rsp_result <= w_fix_result;
      end
   end

endmodule

// File: tb/tb_core_pipe_exec_div_seq.sv
// Directed bench for core_pipe_exec_div_seq: hand-computed quotients/remainders, latency,
// ALU claim count, handshake hold, flush and reset behaviour. The bench models the ALU.
module tb_core_pipe_exec_div_seq;
   localparam int XLEN = 64;
   localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

   logic            g_clk = 1'b0;
   logic            g_reset;
   logic            flush;
   logic            req_valid;
   logic            req_ready;
   logic [1:0]      req_op;
   logic            req_word;
   logic [XLEN-1:0] req_rs1;
   logic [XLEN-1:0] req_rs2;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_result;
   logic            alu_claim;
   logic [XLEN-1:0] alu_opr_a;
   logic [XLEN-1:0] alu_opr_b;
   logic            alu_op_sub;
   logic            alu_word;
   logic [XLEN-1:0] alu_add_out;
   logic            alu_cmp_ltu;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 g_clk = ~g_clk;

   // Execute-stage ALU stand-in
   always_comb begin
      alu_add_out = alu_op_sub ? (alu_opr_a - alu_opr_b) : (alu_opr_a + alu_opr_b);
      alu_cmp_ltu = (alu_opr_a < alu_opr_b);
   end

   core_pipe_exec_div_seq #(.XLEN(XLEN)) dut (
      .g_clk       (g_clk),
      .g_reset     (g_reset),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_word    (req_word),
      .req_rs1     (req_rs1),
      .req_rs2     (req_rs2),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .alu_claim   (alu_claim),
      .alu_opr_a   (alu_opr_a),
      .alu_opr_b   (alu_opr_b),
      .alu_op_sub  (alu_op_sub),
      .alu_word    (alu_word),
      .alu_add_out (alu_add_out),
      .alu_cmp_ltu (alu_cmp_ltu)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] a, input logic [63:0] b);
      int w = 0;
      while (!req_ready && w < 100) begin
         tick();
         w++;
      end
      check("ready_before_issue", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_word  = word;
      req_rs1   = a;
      req_rs2   = b;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                         input int exp_lat, input int exp_claims, input int hold);
      int lat    = 1;
      int claims = 0;
      issue(op, word, a, b);
      while (!rsp_valid && lat < 200) begin
         claims += int'(alu_claim);
         tick();
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_claims"}, 64'(claims), 64'(exp_claims));
      check({tag, "_result"}, rsp_result, exp);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
         check({tag, "_hold_result"}, rsp_result, exp);
         check({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
      check({tag, "_idle_valid"}, 64'(rsp_valid), 64'd0);
   endtask

   initial begin
      int lat;
      int seen_valid;
      g_reset   = 1'b1;
      flush     = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'd0;
      req_word  = 1'b0;
      req_rs1   = '0;
      req_rs2   = '0;
      rsp_ready = 1'b0;
      tick();
      tick();
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_result", rsp_result, 64'd0);
      check("rst_alu_claim", 64'(alu_claim), 64'd0);
      check("rst_alu_opr_a", alu_opr_a, 64'd0);
      check("rst_alu_opr_b", alu_opr_b, 64'd0);
      check("rst_alu_op_sub", 64'(alu_op_sub), 64'd0);
      check("rst_alu_word", 64'(alu_word), 64'd0);
      g_reset = 1'b0;
      tick();

      // Normal 64-bit and word operations
      run_op("divu_100_7", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66, 64, 0);
      run_op("remu_100_7", REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66, 64, 0);
      run_op("div_m7_2", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 64, 0);
      run_op("rem_m7_2", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 64, 0);
      run_op("rem_7_m2", REM, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66, 64, 0);
      run_op("divuw", DIVU, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 34, 32, 0);
      run_op("divw", DIV, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 34, 32, 0);
      run_op("remuw", REMU, 1'b1, 64'hABCD_0000_0000_0011, 64'd4, 64'd1, 34, 32, 0);

      // Special cases: result at T+1, no ALU claim
      run_op("div_by_zero", DIV, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
      run_op("rem_by_zero", REM, 1'b0, 64'h1234, 64'd0, 64'h1234, 1, 0, 0);
      run_op("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0, 0);
      run_op("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, 0);
      run_op("divw_ovf", DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0, 0);
      run_op("remuw_by_zero", REMU, 1'b1, 64'h0000_0000_8000_0001, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0001, 1, 0, 0);

      // Response held for 5 cycles while the consumer stalls
      run_op("hold_divu", DIVU, 1'b0, 64'd1000, 64'd10, 64'd100, 66, 64, 5);

      // Flush during ITER cycle 10
      issue(DIVU, 1'b0, 64'd100, 64'd7);
      lat = 1;
      while (lat < 10) begin
         tick();
         lat++;
      end
      check("flush_pre_claim", 64'(alu_claim), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_req_ready", 64'(req_ready), 64'd1);
      check("flush_alu_claim", 64'(alu_claim), 64'd0);
      check("flush_rsp_valid", 64'(rsp_valid), 64'd0);
      seen_valid = 0;
      for (int i = 0; i < 70; i++) begin
         seen_valid += int'(rsp_valid);
         tick();
      end
      check("flush_no_response", 64'(seen_valid), 64'd0);
      run_op("after_flush_divu", DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 66, 64, 0);

      // Flush in the accept cycle discards the request
      req_valid = 1'b1;
      req_op    = DIVU;
      req_word  = 1'b0;
      req_rs1   = 64'd50;
      req_rs2   = 64'd5;
      flush     = 1'b1;
      tick();
      req_valid = 1'b0;
      flush     = 1'b0;
      check("flush_accept_ready", 64'(req_ready), 64'd1);
      check("flush_accept_claim", 64'(alu_claim), 64'd0);
      check("flush_accept_valid", 64'(rsp_valid), 64'd0);

      // Reset mid-operation
      issue(DIVU, 1'b0, 64'd50, 64'd5);
      tick();
      tick();
      g_reset = 1'b1;
      tick();
      g_reset = 1'b0;
      check("midrst_req_ready", 64'(req_ready), 64'd1);
      check("midrst_alu_claim", 64'(alu_claim), 64'd0);
      check("midrst_rsp_result", rsp_result, 64'd0);
      check("midrst_alu_opr_a", alu_opr_a, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
